// File: rtl/fir_pkg.sv
// Shared types and defaults for the folded-FIR sample pacer.
// State encoding, default sizes and the phase-step helper.
package fir_pkg;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_FOLD_PERIOD = 29;
  localparam int DEF_DEPTH       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic [7:0] next_phase(
    input logic [7:0] p,
    input int unsigned period
  );
    return (p == 8'(period - 1)) ? 8'd0 : p + 8'd1;
  endfunction

endpackage

// File: rtl/fir_sample_pacer_if.sv
// Upstream sample stream into the pacer FIFO.
// Valid/ready handshake; source is master, pacer is slave.
interface fir_sample_pacer_if
  import fir_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic                    s_valid;
  logic signed [WIDTH-1:0] s_data;
  logic                    s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/fir_pacer_fifo.sv
// Sample FIFO for the pacer: storage, pointers, occupancy.
// Push/pop are internally guarded against full/empty.
module fir_pacer_fifo
  import fir_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic signed [WIDTH-1:0] i_data,
  input  logic                    i_pop,
  output logic signed [WIDTH-1:0] o_head,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic                    o_empty,
  output logic                    o_ready
);
  localparam int AW = $clog2(DEPTH);

  logic signed [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]           r_wr;
  logic [AW-1:0]           r_rd;
  logic [AW:0]             r_level;
  logic                    w_push;
  logic                    w_pop;

  assign o_empty = (r_level == '0);
  assign o_ready = (r_level < (AW+1)'(DEPTH));
  assign w_push  = i_push && o_ready;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd];
  assign o_level = r_level;

  // storage write, no reset needed
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// File: rtl/fir_sample_pacer.sv
// Paces FIFO samples into a folded FIR, one every FOLD_PERIOD cycles.
// Optional underrun counter: define FIR_PACER_UNDERRUN_CNT_EN.
module fir_sample_pacer
  import fir_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int FOLD_PERIOD = DEF_FOLD_PERIOD,
  parameter int DEPTH       = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  fir_sample_pacer_if.slave       s,
  input  logic                    start,
  input  logic                    stop,
  output logic                    fir_en,
  output logic signed [WIDTH-1:0] fir_din,
  output logic                    sample_strobe,
  output logic                    underrun,
  output logic [$clog2(DEPTH):0]  level
`ifdef FIR_PACER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]             underrun_cnt
`endif
);
  state_t                  r_state;
  logic [7:0]              r_phase;
  logic                    r_last_empty;
  logic                    r_fir_en;
  logic signed [WIDTH-1:0] r_din;
  logic                    r_strobe;
  logic                    r_underrun;

  logic signed [WIDTH-1:0] w_head;
  logic                    w_empty;
  logic                    w_ready;
  logic                    w_issue;
  logic                    w_start;
  logic                    w_done;
  logic                    w_slot;
  logic                    w_pop;

  // slot edge: phase back at 0 while pacing
  assign w_issue = (r_state != IDLE) && (r_phase == 8'd0);
  assign w_start = (r_state == IDLE) && start;
  // drain ends one period after a slot found the FIFO empty
  assign w_done  = w_issue && (r_state == DRAIN) && r_last_empty;
  assign w_slot  = w_start || (w_issue && !w_done);
  assign w_pop   = w_slot && !w_empty;

  assign s.s_ready     = w_ready;
  assign fir_en        = r_fir_en;
  assign fir_din       = r_din;
  assign sample_strobe = r_strobe;
  assign underrun      = r_underrun;

  fir_pacer_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (s.s_valid),
    .i_data  (s.s_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_level (level),
    .o_empty (w_empty),
    .o_ready (w_ready)
  );

  // pacing FSM, phase counter and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_phase      <= 8'd0;
      r_last_empty <= 1'b0;
      r_fir_en     <= 1'b0;
      r_din        <= '0;
      r_strobe     <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_strobe   <= w_slot;
      r_underrun <= w_slot && w_empty;
      r_din      <= w_pop ? w_head : '0;
      if (w_slot) r_last_empty <= w_empty;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state  <= RUN;
            r_fir_en <= 1'b1;
            r_phase  <= 8'd1;
          end
        end
        RUN: begin
          r_phase <= next_phase(r_phase, FOLD_PERIOD);
          if (stop) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_done) begin
            r_state  <= IDLE;
            r_fir_en <= 1'b0;
            r_phase  <= 8'd0;
          end else begin
            r_phase <= next_phase(r_phase, FOLD_PERIOD);
          end
        end
        default: begin
          r_state  <= IDLE;
          r_fir_en <= 1'b0;
          r_phase  <= 8'd0;
        end
      endcase
    end
  end

`ifdef FIR_PACER_UNDERRUN_CNT_EN
  logic [15:0] r_ucnt;

  // saturating count of underrun slots
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ucnt <= '0;
    end else if (w_slot && w_empty && (r_ucnt != 16'hFFFF)) begin
      r_ucnt <= r_ucnt + 16'd1;
    end
  end

  assign underrun_cnt = r_ucnt;
`endif
endmodule

// File: tb/tb_fir_sample_pacer.sv
// Bench for fir_sample_pacer: scoreboard of issued samples.
// Expected values queued at push time, popped on each strobe.
module tb_fir_sample_pacer;
  import fir_pkg::*;

  localparam int W = 16;
  localparam int P = 29;

  typedef struct packed {
    logic [W-1:0] d;
    logic         und;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic fir_en;
  logic signed [W-1:0] fir_din;
  logic sample_strobe;
  logic underrun;
  logic [3:0] level;
`ifdef FIR_PACER_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  int   strobe_cyc[$];

  fir_sample_pacer_if #(.WIDTH(W)) sif ();

  fir_sample_pacer #(
    .WIDTH       (W),
    .FOLD_PERIOD (P),
    .DEPTH       (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s             (sif),
    .start         (start),
    .stop          (stop),
    .fir_en        (fir_en),
    .fir_din       (fir_din),
    .sample_strobe (sample_strobe),
    .underrun      (underrun),
    .level         (level)
`ifdef FIR_PACER_UNDERRUN_CNT_EN
    ,
    .underrun_cnt  (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // scoreboard: every strobe must match the queue head
  always @(negedge clk) begin
    if (rst) begin
      if (sample_strobe) begin
        strobe_cyc.push_back(cyc);
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_extra cyc=%0d din=%h und=%b exp=none",
                   cyc, fir_din, underrun);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (fir_din !== e.d || underrun !== e.und) begin
            n_err++;
            $display("FAIL sb_data cyc=%0d din=%h und=%b exp din=%h und=%b",
                     cyc, fir_din, underrun, e.d, e.und);
          end
        end
      end else if (fir_din !== '0 || underrun !== 1'b0) begin
        n_vec++;
        n_err++;
        $display("FAIL idle_out cyc=%0d din=%h und=%b exp din=0 und=0",
                 cyc, fir_din, underrun);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_data = '0;
    start = 1'b0;
    stop = 1'b0;
    tick();
    tick();
    exp_q.delete();
    strobe_cyc.delete();
    rst = 1'b1;
  endtask

  task automatic push(input logic [W-1:0] d);
    sif.s_valid = 1'b1;
    sif.s_data = d;
    exp_q.push_back('{d: d, und: 1'b0});
    tick();
    sif.s_valid = 1'b0;
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    s = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_vec += 6;
    if (fir_en !== 1'b0) begin
      n_err++; $display("FAIL rst_fir_en got=%b exp=0", fir_en);
    end
    if (level !== 4'd0) begin
      n_err++; $display("FAIL rst_level got=%0d exp=0", level);
    end
    if (sif.s_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_ready got=%b exp=1", sif.s_ready);
    end
    if (sample_strobe !== 1'b0) begin
      n_err++; $display("FAIL rst_strobe got=%b exp=0", sample_strobe);
    end
    if (underrun !== 1'b0) begin
      n_err++; $display("FAIL rst_underrun got=%b exp=0", underrun);
    end
    if (fir_din !== '0) begin
      n_err++; $display("FAIL rst_din got=%h exp=0", fir_din);
    end
  endtask

  task automatic test_basic();
    int s;
    do_reset();
    push(16'h0010);
    push(16'hFFF0);
    push(16'h7FFF);
    n_vec++;
    if (level !== 4'd3) begin
      n_err++; $display("FAIL basic_level got=%0d exp=3", level);
    end
    pulse_start(s);
    repeat (60) tick();
    n_vec++;
    if (strobe_cyc.size() != 3) begin
      n_err++;
      $display("FAIL basic_count got=%0d exp=3", strobe_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (strobe_cyc[i] != s + i * P) begin
          n_err++;
          $display("FAIL basic_slot%0d got=%0d exp=%0d",
                   i, strobe_cyc[i], s + i * P);
        end
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL basic_left got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_full();
    int s;
    do_reset();
    sif.s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sif.s_data = 16'(100 + i);
      exp_q.push_back('{d: 16'(100 + i), und: 1'b0});
      tick();
    end
    sif.s_data = 16'd108;
    repeat (3) tick();
    n_vec += 2;
    if (sif.s_ready !== 1'b0) begin
      n_err++; $display("FAIL full_ready got=%b exp=0", sif.s_ready);
    end
    if (level !== 4'd8) begin
      n_err++; $display("FAIL full_level got=%0d exp=8", level);
    end
    exp_q.push_back('{d: 16'd108, und: 1'b0});
    pulse_start(s);
    n_vec += 2;
    if (level !== 4'd7) begin
      n_err++; $display("FAIL full_pop_level got=%0d exp=7", level);
    end
    if (sif.s_ready !== 1'b1) begin
      n_err++; $display("FAIL full_pop_ready got=%b exp=1", sif.s_ready);
    end
    tick();
    sif.s_valid = 1'b0;
    n_vec++;
    if (level !== 4'd8) begin
      n_err++; $display("FAIL full_9th_level got=%0d exp=8", level);
    end
  endtask

  task automatic test_underrun();
    int s;
    do_reset();
    repeat (3) exp_q.push_back('{d: '0, und: 1'b1});
    pulse_start(s);
    repeat (59) tick();
    n_vec++;
    if (strobe_cyc.size() != 3) begin
      n_err++;
      $display("FAIL und_count got=%0d exp=3", strobe_cyc.size());
    end else begin
      n_vec++;
      if (strobe_cyc[2] != s + 2 * P) begin
        n_err++;
        $display("FAIL und_slot2 got=%0d exp=%0d", strobe_cyc[2], s + 2 * P);
      end
    end
`ifdef FIR_PACER_UNDERRUN_CNT_EN
    n_vec++;
    if (underrun_cnt !== 16'd3) begin
      n_err++; $display("FAIL und_cnt got=%0d exp=3", underrun_cnt);
    end
`endif
  endtask

  task automatic test_drain();
    int s;
    do_reset();
    push(16'h1111);
    push(16'hA5A5);
    pulse_start(s);
    repeat (10) tick();
    stop = 1'b1;
    exp_q.push_back('{d: '0, und: 1'b1});
    tick();
    stop = 1'b0;
    while (cyc < s + 3 * P - 1) tick();
    n_vec++;
    if (fir_en !== 1'b1) begin
      n_err++; $display("FAIL drain_en_hold got=%b exp=1", fir_en);
    end
    tick();
    n_vec += 2;
    if (fir_en !== 1'b0) begin
      n_err++; $display("FAIL drain_en_fall got=%b exp=0", fir_en);
    end
    if (dut.r_state !== IDLE) begin
      n_err++; $display("FAIL drain_state got=%0d exp=%0d", dut.r_state, IDLE);
    end
    repeat (40) tick();
    n_vec++;
    if (strobe_cyc.size() != 3) begin
      n_err++;
      $display("FAIL drain_count got=%0d exp=3", strobe_cyc.size());
    end else begin
      n_vec++;
      if (strobe_cyc[2] != s + 2 * P) begin
        n_err++;
        $display("FAIL drain_slot2 got=%0d exp=%0d", strobe_cyc[2], s + 2 * P);
      end
    end
  endtask

  task automatic test_reset_abort();
    int s;
    do_reset();
    push(16'h0001);
    push(16'h0002);
    push(16'h0003);
    pulse_start(s);
    repeat (9) tick();
    rst = 1'b0;
    tick();
    n_vec += 3;
    if (fir_en !== 1'b0) begin
      n_err++; $display("FAIL abort_en got=%b exp=0", fir_en);
    end
    if (level !== 4'd0) begin
      n_err++; $display("FAIL abort_level got=%0d exp=0", level);
    end
    if (sample_strobe !== 1'b0) begin
      n_err++; $display("FAIL abort_strobe got=%b exp=0", sample_strobe);
    end
    exp_q.delete();
    rst = 1'b1;
    repeat (70) tick();
    n_vec++;
    if (strobe_cyc.size() != 1) begin
      n_err++;
      $display("FAIL abort_count got=%0d exp=1", strobe_cyc.size());
    end
  endtask

  task automatic test_same_edge();
    int s;
    do_reset();
    for (int i = 0; i < 5; i++) push(16'(16'h0200 + i));
    pulse_start(s);
    while (cyc < s + P - 1) tick();
    n_vec++;
    if (level !== 4'd4) begin
      n_err++; $display("FAIL same_pre_level got=%0d exp=4", level);
    end
    sif.s_valid = 1'b1;
    sif.s_data = 16'h1234;
    exp_q.push_back('{d: 16'h1234, und: 1'b0});
    tick();
    sif.s_valid = 1'b0;
    n_vec += 2;
    if (level !== 4'd4) begin
      n_err++; $display("FAIL same_level got=%0d exp=4", level);
    end
    if (sample_strobe !== 1'b1) begin
      n_err++; $display("FAIL same_strobe got=%b exp=1", sample_strobe);
    end
  endtask

  initial begin
    sif.s_valid = 1'b0;
    sif.s_data = '0;
    test_reset();
    test_basic();
    test_full();
    test_underrun();
    test_drain();
    test_reset_abort();
    test_same_edge();
    do_reset();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fir_sample_pacer.md
FIR_SAMPLE_PACER -- requirements
Module: fir_sample_pacer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample width in bits.
REQ-002 SHALL have parameter FOLD_PERIOD, default 29, clock cycles between issued samples (the folded-FIR period); legal range 2..255.
REQ-003 SHALL have parameter DEPTH, default 8, input FIFO entries; power of two.
REQ-004 SHALL have port clk  in  1  clock; all logic on the rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-low reset.
REQ-006 SHALL have port s_valid  in  1  upstream sample valid.
REQ-007 SHALL have port s_data  in  WIDTH  upstream sample, signed.
REQ-008 SHALL have port s_ready  out  1  FIFO can accept a sample.
REQ-009 SHALL have port start  in  1  one-cycle pulse that begins pacing.
REQ-010 SHALL have port stop  in  1  one-cycle pulse that requests drain-then-idle.
REQ-011 SHALL have port fir_en  out  1  enable to the downstream FIR.
REQ-012 SHALL have port fir_din  out  WIDTH  sample to the FIR, signed; zero outside issue cycles.
REQ-013 SHALL have port sample_strobe  out  1  high in each issue cycle.
REQ-014 SHALL have port underrun  out  1  one-cycle pulse when an issue slot finds the FIFO empty.
REQ-015 SHALL have port level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 SHALL accept a push on any edge with s_valid=1 and s_ready=1; s_ready = (level < DEPTH), derived from registered level.
REQ-017 SHALL keep level unchanged on a simultaneous push and pop; SHALL never push when full or pop when empty.
REQ-018 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN on stop; DRAIN->IDLE on the edge that completes the period in which an issue slot found the FIFO empty.
REQ-019 SHALL ignore start outside IDLE and stop outside RUN; start and stop together in IDLE SHALL behave as start only.
REQ-020 SHALL, on the edge where IDLE->RUN is taken, register an issue (fir_en=1, sample_strobe=1) and reset the phase counter to 1; subsequent issue edges SHALL occur every FOLD_PERIOD edges while in RUN or DRAIN.
REQ-021 SHALL, at an issue edge with a non-empty FIFO, pop the head into fir_din; with an empty FIFO, drive fir_din=0, sample_strobe=1, underrun=1 for that cycle.
REQ-022 SHALL drive fir_din=0 and sample_strobe=0 in every non-issue cycle; underrun SHALL last exactly one cycle.
REQ-023 SHALL hold fir_en=1 throughout RUN and DRAIN and 0 in IDLE.
REQ-024 SHALL wrap the phase counter FOLD_PERIOD-1 -> 0 without skipping or repeating a slot.
REQ-025 SHALL allow pushes in every state, including IDLE.

Reset
REQ-026 SHALL, when rst=0 at an edge, set state=IDLE, empty the FIFO, level=0, phase=0, fir_en=0, fir_din=0, sample_strobe=0, underrun=0; s_ready=1 following.
REQ-027 SHALL abort any RUN/DRAIN activity on reset with no further issue.

Configuration
REQ-028 SHALL, with macro FIR_PACER_UNDERRUN_CNT_EN defined, add output underrun_cnt (16 bits) counting underrun pulses, saturating at 16'hFFFF, cleared by reset only.
REQ-029 SHALL, without FIR_PACER_UNDERRUN_CNT_EN, omit the underrun_cnt port and counter; all other behaviour identical.

Structure
REQ-030 SHALL place state encoding (IDLE/RUN/DRAIN) and default WIDTH/FOLD_PERIOD/DEPTH constants in shared package fir_pkg.
REQ-031 SHALL implement the FIFO as one sub-module, fir_pacer_fifo (storage, pointers, level); pacing FSM and phase counter in the top.

Verification
REQ-032 SHALL cover: reset, push 3 samples (0x0010, 0xFFF0, 0x7FFF), start -> strobes at start edge +0, +29, +58 carrying those values in order; fir_din=0 elsewhere.
REQ-033 SHALL cover: push 8 samples with s_valid held -> s_ready=0 with level=8; 9th sample not accepted until first pop.
REQ-034 SHALL cover: start with empty FIFO -> strobe with fir_din=0 and underrun=1 at each slot; with macro, underrun_cnt=3 after 3 slots.
REQ-035 SHALL cover: 2 samples queued, stop mid-period -> both issued, third slot underruns, fir_en falls 29 cycles later, state IDLE.
REQ-036 SHALL cover: rst=0 asserted 10 cycles after start -> next edge fir_en=0, level=0, no strobe thereafter.
REQ-037 SHALL cover: push and pop on the same issue edge at level=4 -> level remains 4.
